frame_tx_scheduler: RTL and testbench
=====================================

# frame_tx_scheduler

Sequences whole-frame transmission over the UART pixel link and shares it between two frame sources: the test-image ROM (source 0) and the camera frame buffer (source 1). It arbitrates requests round-robin per frame and emits the start-marker pixel. It then walks read addresses through the granted source with fixed read latency and hands each 12-bit pixel to the downstream serializer over a valid/ready handshake. It sits between the frame memories and the pixel serializer, replacing free-running address generation inside the sender.

## Interface
Parameters:
- NUM_PIXELS, 76800: pixels per frame (320x240).
- ADDR_WIDTH, 17: read address width; must satisfy 2^ADDR_WIDTH >= NUM_PIXELS.
- READ_LATENCY, 2: cycles from rd_addr change to valid rd_data; legal range 1..4.
- START_PIXEL, 12'h00A: marker pixel sent before pixel 0.
- GAP_CYCLES, 0: idle cycles enforced after each frame end or abort.

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  reset; asynchronous, active-high.
- req  in  2  per-source frame request; level, sampled only in IDLE.
- abort  in  1  cancels the frame in progress.
- grant  out  2  one-hot owner of the link; held for the whole frame.
- rd_addr  out  ADDR_WIDTH  pixel read address to both memories.
- rd_data0  in  12  source 0 read data.
- rd_data1  in  12  source 1 read data.
- tx_data  out  12  pixel to serializer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serializer accepts.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel of a completed frame is transferred.
- frames_sent  out  16  completed-frame count; wraps 0xFFFF->0.

## Operation
- States: IDLE, HEADER, FETCH, SEND, GAP.
- IDLE: if req != 0, register grant and go to HEADER.
  - If exactly one request is set, that source wins.
  - If both are set, the source not granted last wins.
  - The last-served pointer resets to 1, so source 0 wins the first tie.
- HEADER: tx_data=START_PIXEL, tx_valid=1, rd_addr=0. On transfer (tx_valid&&tx_ready at an edge), go to FETCH.
- FETCH: hold rd_addr and count READ_LATENCY cycles. Capture rd_data of the granted source into tx_data, then go to SEND.
- SEND: tx_valid=1.
  - On transfer with rd_addr < NUM_PIXELS-1: rd_addr+1, go to FETCH.
  - On transfer with rd_addr == NUM_PIXELS-1: pulse frame_done, increment frames_sent, go to GAP.
- GAP: grant=0, rd_addr=0. Wait GAP_CYCLES cycles, then go to IDLE. GAP_CYCLES=0 means direct to IDLE on the next edge.
- Transfer rule: a transfer occurs only when tx_valid&&tx_ready at an edge. tx_ready while tx_valid=0 is ignored. tx_data is stable while tx_valid&&!tx_ready.
- abort:
  - Honoured in HEADER, FETCH and SEND; go to GAP on the next edge.
  - tx_valid drops immediately. No frame_done, no count increment.
  - abort takes priority over a coincident transfer.
  - Ignored in IDLE and GAP.
- Request deassertion mid-frame is ignored; the frame completes. Requests held through GAP are re-arbitrated in IDLE.
- rd_addr changes only on FETCH entry; the granted mux source never changes mid-frame.

## Timing
- Reset values: grant=0, rd_addr=0, tx_data=0, tx_valid=0, busy=0, frame_done=0, frames_sent=0, state IDLE. Reset mid-frame returns to these immediately, asynchronously.
- Request to first valid: req sampled at edge N gives grant, busy and tx_valid(START_PIXEL) high after edge N.
- Header transfer at edge E: FETCH from E. Pixel captured at edge E+READ_LATENCY. tx_valid high after that edge.
- Per pixel with tx_ready held high: READ_LATENCY+1 cycles. Frame minimum: 1 + NUM_PIXELS*(READ_LATENCY+1) cycles.
- frame_done and the frames_sent update occur in the same cycle, the one after the final transfer edge. grant is low from that cycle.
- Back-to-back frames: with GAP_CYCLES=0, the next grant is available 2 cycles after the final transfer edge.

## Test plan
- Reset and single request:
  - Stimulus: NUM_PIXELS=4, READ_LATENCY=2, ROM0 data 0x100..0x103, req=01, tx_ready=1.
  - Required response: serializer sees 0x00A, 0x100, 0x101, 0x102, 0x103. frame_done pulses once, frames_sent=1, grant returns to 0.
- Tie arbitration:
  - Stimulus: req=11 held for three frames.
  - Required response: grants 01, 10, 01. frames_sent=3.
- Backpressure:
  - Stimulus: tx_ready low for 5 cycles during header and pixel 2.
  - Required response: tx_data held constant while stalled, no pixel lost or duplicated, output order unchanged.
- Abort:
  - Stimulus: pulse abort while SEND holds pixel 1.
  - Required response: tx_valid low next cycle, no frame_done, frames_sent unchanged. A held req is re-arbitrated after GAP.
- Async reset:
  - Stimulus: assert rst mid-FETCH, off a clock edge.
  - Required response: all outputs at reset values before the next edge. A new frame restarts from the header with rd_addr=0.
- Counter wrap:
  - Stimulus: preload or force frames_sent=0xFFFF, complete one frame.
  - Required response: frames_sent=0x0000, frame_done pulses.

Source files
------------

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler
// Shares the UART pixel link between two frame sources and sends one whole
// frame at a time. Source 0 is the test-image ROM and source 1 is the camera
// frame buffer. Arbitration is round-robin per frame. Each frame is a start
// marker pixel followed by NUM_PIXELS pixels read at fixed latency. Every
// pixel goes to the serializer over a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   req[1:0]     per-source frame request (level, sampled only in IDLE)
//   abort        cancels the frame in progress
//   grant[1:0]   one-hot link owner, held for the whole frame
//   rd_addr      pixel read address to both memories
//   rd_data0/1   source 0 / source 1 read data
//   tx_data      pixel to serializer
//   tx_valid     tx_data valid
//   tx_ready     serializer accepts
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse after the last pixel of a completed frame
//   frames_sent  completed-frame count, wraps 0xFFFF -> 0
//
// READ_LATENCY must lie in 1..4.
// 2**ADDR_WIDTH must be >= NUM_PIXELS.
module frame_tx_scheduler #(
  parameter int unsigned NUM_PIXELS   = 76800,
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [11:0] START_PIXEL  = 12'h00A,
  parameter int unsigned GAP_CYCLES   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic                  abort,
  output logic [1:0]            grant,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [11:0]           rd_data0,
  input  logic [11:0]           rd_data1,
  output logic [11:0]           tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frames_sent
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(READ_LATENCY - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    FETCH  = 3'd2,
    SEND   = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t                  state, state_n;
  logic [1:0]              grant_n;
  logic [ADDR_WIDTH-1:0]   rd_addr_n;
  logic [11:0]             tx_data_n;
  logic                    tx_valid_n;
  logic                    busy_n;
  logic                    frame_done_n;
  logic [15:0]             frames_sent_n;
  // Index of the source granted most recently; resets to 1 so source 0 wins the first tie.
  logic                    last_src, last_src_n;
  logic [LAT_W-1:0]        lat_cnt, lat_cnt_n;
  logic [GAP_W-1:0]        gap_cnt, gap_cnt_n;

  logic                    xfer;
  logic                    pick;
  logic                    enter_gap;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 2'b00;
      rd_addr     <= '0;
      tx_data     <= 12'h000;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frames_sent <= 16'h0000;
      last_src    <= 1'b1;
      lat_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      rd_addr     <= rd_addr_n;
      tx_data     <= tx_data_n;
      tx_valid    <= tx_valid_n;
      busy        <= busy_n;
      frame_done  <= frame_done_n;
      frames_sent <= frames_sent_n;
      last_src    <= last_src_n;
      lat_cnt     <= lat_cnt_n;
      gap_cnt     <= gap_cnt_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    grant_n       = grant;
    rd_addr_n     = rd_addr;
    tx_data_n     = tx_data;
    tx_valid_n    = tx_valid;
    frame_done_n  = 1'b0;
    frames_sent_n = frames_sent;
    last_src_n    = last_src;
    lat_cnt_n     = lat_cnt;
    gap_cnt_n     = gap_cnt;
    xfer          = tx_valid && tx_ready;
    pick          = 1'b0;
    enter_gap     = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          // A tie goes to the source that was not served last.
          pick       = (req == 2'b11) ? ~last_src : req[1];
          grant_n    = pick ? 2'b10 : 2'b01;
          last_src_n = pick;
          rd_addr_n  = '0;
          tx_data_n  = START_PIXEL;
          tx_valid_n = 1'b1;
          state_n    = HEADER;
        end
      end

      HEADER: begin
        if (abort) begin
          enter_gap = 1'b1;
        end else if (xfer) begin
          tx_valid_n = 1'b0;
          lat_cnt_n  = '0;
          state_n    = FETCH;
        end
      end

      FETCH: begin
        if (abort) begin
          enter_gap = 1'b1;
        end else if (lat_cnt == LAT_LAST) begin
          // The grant cannot change mid-frame, so this mux select is stable for the frame.
          tx_data_n  = grant[1] ? rd_data1 : rd_data0;
          tx_valid_n = 1'b1;
          state_n    = SEND;
        end else begin
          lat_cnt_n = lat_cnt + 1'b1;
        end
      end

      SEND: begin
        // Abort wins over a transfer on the same edge.
        if (abort) begin
          enter_gap = 1'b1;
        end else if (xfer) begin
          if (rd_addr == LAST_ADDR) begin
            frame_done_n  = 1'b1;
            frames_sent_n = frames_sent + 16'd1;
            enter_gap     = 1'b1;
          end else begin
            rd_addr_n  = rd_addr + 1'b1;
            tx_valid_n = 1'b0;
            lat_cnt_n  = '0;
            state_n    = FETCH;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Frame end and abort both release the link and park the address.
    if (enter_gap) begin
      state_n    = GAP;
      grant_n    = 2'b00;
      rd_addr_n  = '0;
      tx_valid_n = 1'b0;
      gap_cnt_n  = '0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Randomized scoreboard bench for frame_tx_scheduler.
// The stimulus pushes the expected pixel stream and completion counts.
// A negedge monitor pops and compares them on every transfer and frame_done.
module tb_frame_tx_scheduler;

  localparam int unsigned NP  = 4;
  localparam int unsigned AW  = 3;
  localparam int unsigned RL  = 2;
  localparam int unsigned GAPC = 0;
  localparam logic [11:0] SP  = 12'h00A;
  localparam int          HI  = (RL > 1) ? RL - 2 : 0;

  logic          clk;
  logic          rst;
  logic [1:0]    req;
  logic          abort;
  logic [1:0]    grant;
  logic [AW-1:0] rd_addr;
  logic [11:0]   rd_data0;
  logic [11:0]   rd_data1;
  logic [11:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frames_sent;

  frame_tx_scheduler #(
    .NUM_PIXELS(NP), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
    .START_PIXEL(SP), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .abort(abort), .grant(grant),
    .rd_addr(rd_addr), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame memories: data appears after READ_LATENCY cycles of a stable address
  logic [11:0]   rom0 [0:(1<<AW)-1];
  logic [11:0]   rom1 [0:(1<<AW)-1];
  logic [AW-1:0] ahist [0:3];

  always @(posedge clk) begin
    ahist[0] <= rd_addr;
    for (int i = 1; i < 4; i++) ahist[i] <= ahist[i-1];
  end

  wire [AW-1:0] maddr = (RL == 1) ? rd_addr : ahist[HI];
  assign rd_data0 = rom0[maddr];
  assign rd_data1 = rom1[maddr];

  // Scoreboard
  typedef struct packed {
    logic [11:0] px;
    logic [1:0]  gnt;
  } item_t;

  item_t       exp_q[$];
  logic [15:0] cnt_q[$];
  bit          last_src  = 1'b1;
  logic [15:0] cnt_model = 16'h0000;

  logic        stalled = 1'b0;
  logic [11:0] held    = 12'h000;

  // Monitor: compares every transfer, output stability under stall, and every frame_done
  always @(negedge clk) begin
    if (rst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled && tx_valid) check("hold_stable", 32'(tx_data), 32'(held));
      if (tx_valid && tx_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer: got tx_data 0x%0h with no expected pixel", tx_data);
        end else begin
          check("px", 32'(tx_data), 32'(exp_q[0].px));
          check("grant_xfer", 32'(grant), 32'(exp_q[0].gnt));
          void'(exp_q.pop_front());
        end
      end
      stalled <= tx_valid && !tx_ready && !abort;
      held    <= tx_data;
      if (frame_done) begin
        if (cnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got frame_done with frames_sent 0x%0h", frames_sent);
        end else begin
          check("frames_sent", 32'(frames_sent), 32'(cnt_q[0]));
          void'(cnt_q.pop_front());
        end
        check("grant_at_done", 32'(grant), 32'h0);
        check("valid_at_done", 32'(tx_valid), 32'h0);
      end
    end
  end

  task automatic fill_roms(input bit incr);
    for (int i = 0; i < (1 << AW); i++) begin
      if (i >= int'(NP)) begin
        rom0[i] = 12'hEEE;
        rom1[i] = 12'hEEE;
      end else begin
        rom0[i] = incr ? 12'(256 + i) : 12'($urandom);
        rom1[i] = incr ? 12'(512 + i) : 12'($urandom);
      end
    end
  endtask

  // Reference arbitration: single request wins, a tie goes to the source not served last
  task automatic arbitrate(input logic [1:0] r, output logic [1:0] g);
    bit win;
    if (r == 2'b11) win = !last_src;
    else            win = r[1];
    last_src = win;
    g = win ? 2'b10 : 2'b01;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [1:0] r, input bit hold, input bit stall_hdr,
                           input bit stall_px2, input bit do_abort, input bit rnd_ready,
                           input bit chk_b2b);
    logic [1:0] g;
    int  xf, s_hdr, s_px;
    bit  ok, aborted, done_seen, idle_seen;
    arbitrate(r, g);
    exp_q.push_back({SP, g});
    for (int i = 0; i < int'(NP); i++) exp_q.push_back({(g[1] ? rom1[i] : rom0[i]), g});
    if (!do_abort) begin
      cnt_model = cnt_model + 16'd1;
      cnt_q.push_back(cnt_model);
    end
    req      = r;
    tx_ready = 1'b1;
    wait_busy(ok);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL start_timeout: got busy=0 required busy=1 for req=%b", r);
      return;
    end
    check("grant_at_start", 32'(grant), 32'(g));
    check("addr_at_start", 32'(rd_addr), 32'h0);
    check("hdr_valid", 32'(tx_valid), 32'h1);
    if (chk_b2b) check("b2b_gap", 32'(cyc - done_cyc), 32'd2);
    if (!hold) req = 2'b00;

    xf = 0; s_hdr = 0; s_px = 0; aborted = 1'b0; done_seen = 1'b0;
    for (int c = 0; c < 300 && !done_seen && !aborted; c++) begin
      tx_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      abort    = 1'b0;
      if (tx_valid && xf == 0 && stall_hdr && s_hdr < 5) begin
        tx_ready = 1'b0;
        s_hdr++;
      end
      if (tx_valid && xf == 3 && stall_px2 && s_px < 5) begin
        tx_ready = 1'b0;
        s_px++;
      end
      if (tx_valid && xf == 2 && do_abort) begin
        abort    = 1'b1;
        tx_ready = 1'($urandom_range(0, 1));
        aborted  = 1'b1;
        exp_q.delete();
      end
      if (tx_valid && tx_ready && !abort) xf++;
      @(posedge clk); #1;
      abort = 1'b0;
      if (frame_done) done_seen = 1'b1;
    end

    if (aborted) begin
      check("abort_valid", 32'(tx_valid), 32'h0);
      check("abort_no_done", 32'(frame_done), 32'h0);
      check("abort_count", 32'(frames_sent), 32'(cnt_model));
      check("abort_grant", 32'(grant), 32'h0);
    end else if (!done_seen) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: got %0d transfers required %0d", xf, NP + 1);
    end else begin
      done_cyc = cyc;
      check("pixels_sent", 32'(xf), 32'(NP + 1));
    end

    idle_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    if (!idle_seen) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got busy=1 required busy=0");
    end
  endtask

  task automatic reset_mid_fetch(input logic [1:0] r);
    logic [1:0] g;
    bit ok;
    arbitrate(r, g);
    exp_q.push_back({SP, g});
    req      = r;
    tx_ready = 1'b1;
    wait_busy(ok);
    req = 2'b00;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL rst_start_timeout: got busy=0 required busy=1");
    end
    @(posedge clk); #3;
    check("in_fetch_valid", 32'(tx_valid), 32'h0);
    rst = 1'b1;
    #1;
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_addr", 32'(rd_addr), 32'h0);
    check("arst_data", 32'(tx_data), 32'h0);
    check("arst_valid", 32'(tx_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(frame_done), 32'h0);
    check("arst_count", 32'(frames_sent), 32'h0);
    exp_q.delete();
    cnt_q.delete();
    last_src  = 1'b1;
    cnt_model = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    req      = 2'b00;
    abort    = 1'b0;
    tx_ready = 1'b0;
    fill_roms(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_addr", 32'(rd_addr), 32'h0);
    check("rst_data", 32'(tx_data), 32'h0);
    check("rst_valid", 32'(tx_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    check("rst_count", 32'(frames_sent), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single request from the test-image ROM
    run_frame(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Tie held for three back-to-back frames
    run_frame(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure on header and pixel 2
    fill_roms(1'b0);
    run_frame(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort while pixel 1 is presented; held request is re-arbitrated after GAP
    run_frame(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random sources, data and serializer readiness
    for (int f = 0; f < 8; f++) begin
      fill_roms(1'b0);
      run_frame(2'($urandom_range(1, 3)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-fetch, then fresh tie sequence from reset state
    reset_mid_fetch(2'b10);
    fill_roms(1'b1);
    run_frame(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Completed-frame counter wrap
    force dut.frames_sent = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frames_sent;
    cnt_model = 16'hFFFF;
    run_frame(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    check("count_queue_empty", 32'(cnt_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
